// File: rtl/walk_pkg.sv
// walk_pkg: items shared by the walk request arbiter and its round-robin
// selector.
//   walk_state_e : grant FSM states (idle, offering a grant, serving a walk)
//   ch_width()   : width of a channel index for n crossings, never below 1
package walk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OFFER = 2'd1,
        ST_SERVE = 2'd2
    } walk_state_e;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin selector.
// The search starts at rr_ptr and wraps modulo N_CH. The first set request
// bit found is returned.
//   req    : request vector, one bit per crossing
//   rr_ptr : channel index with the highest priority this cycle
//   grant  : index of the selected channel (0 when no request is set)
//   any    : high when at least one request bit is set
module rr_arbiter
    import walk_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CH_W = ch_width(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] rr_ptr,
    output logic [CH_W-1:0] grant,
    output logic            any
);

    // Walk the offsets from farthest to nearest, so the nearest hit to rr_ptr is written last and wins.
    always_comb begin
        grant = {CH_W{1'b0}};
        any   = 1'b0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            int  idx;
            logic hit;
            idx   = (int'(rr_ptr) + k) % N_CH;
            hit   = req[idx];
            grant = hit ? CH_W'(idx) : grant;
            any   = any | hit;
        end
    end

endmodule

// File: rtl/walk_request_arbiter.sv
// walk_request_arbiter: latches pedestrian walk requests from N_CH
// crossings and ages each pending request. It offers one request at a time
// to the signal controller over a valid/ready handshake and holds the grant
// until the walk phase completes.
//   clk, reset_n   : clock, asynchronous active-low reset
//   wr_sync        : synchronised button levels; a rising edge latches a request
//   wr_clear       : per-channel request cancel
//   svc_ready      : controller can accept the offered grant
//   svc_done       : one-cycle pulse; the granted walk phase has finished
//   wr             : pending request flags
//   urgent         : pending requests that have waited MAX_WAIT cycles
//   svc_valid      : grant offered on svc_ch
//   svc_ch         : channel being offered or served
//   busy           : walk phase in progress
module walk_request_arbiter
    import walk_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int MAX_WAIT = 255,
    parameter  int WAIT_W   = 8,
    localparam int CH_W     = ch_width(N_CH)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N_CH-1:0] wr_sync,
    input  logic [N_CH-1:0] wr_clear,
    input  logic            svc_ready,
    input  logic            svc_done,
    output logic [N_CH-1:0] wr,
    output logic [N_CH-1:0] urgent,
    output logic            svc_valid,
    output logic [CH_W-1:0] svc_ch,
    output logic            busy
);

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    walk_state_e      state_r;
    logic [N_CH-1:0]  sync_prev_r;
    logic [N_CH-1:0]  wr_r;
    logic [N_CH-1:0]  urgent_r;
    logic [WAIT_W-1:0] wait_r [N_CH];
    logic             svc_valid_r;
    logic [CH_W-1:0]  svc_ch_r;
    logic             busy_r;
    logic [CH_W-1:0]  rr_ptr_r;

    logic [N_CH-1:0]  rise_s;
    logic             accept_s;
    logic [N_CH-1:0]  accept_mask_s;
    logic [N_CH-1:0]  clr_s;
    logic [N_CH-1:0]  wr_next_s;
    logic [N_CH-1:0]  urgent_next_s;
    logic [WAIT_W-1:0] wait_next_s [N_CH];
    logic [N_CH-1:0]  cand_s;
    logic [CH_W-1:0]  grant_s;
    logic             any_s;
    logic [CH_W-1:0]  rr_next_s;

    // Request edges, clears and next flag values; a clear always beats a set in the same cycle.
    always_comb begin
        rise_s                  = wr_sync & ~sync_prev_r;
        accept_s                = svc_valid_r & svc_ready;
        accept_mask_s           = {N_CH{1'b0}};
        accept_mask_s[svc_ch_r] = accept_s;
        clr_s                   = wr_clear | accept_mask_s;
        wr_next_s               = (wr_r | rise_s) & ~clr_s;
        // An urgent request pre-empts round-robin fairness among the non-urgent ones.
        cand_s                  = (|urgent_r) ? urgent_r : wr_r;
        rr_next_s               = (svc_ch_r == CH_W'(N_CH - 1)) ? {CH_W{1'b0}}
                                                                : svc_ch_r + CH_W'(1);
    end

    // Per-channel wait counters: start at 0 when a flag sets, saturate at MAX_WAIT, drop to 0 on clear.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            if (!wr_next_s[i]) begin
                wait_next_s[i] = {WAIT_W{1'b0}};
            end else if (wr_r[i]) begin
                wait_next_s[i] = (wait_r[i] == WAIT_MAX) ? wait_r[i] : wait_r[i] + WAIT_W'(1);
            end else begin
                wait_next_s[i] = {WAIT_W{1'b0}};
            end
            urgent_next_s[i] = wr_next_s[i] && (wait_next_s[i] == WAIT_MAX);
        end
    end

    rr_arbiter #(
        .N_CH   (N_CH)
    ) u_rr_arbiter (
        .req    (cand_s),
        .rr_ptr (rr_ptr_r),
        .grant  (grant_s),
        .any    (any_s)
    );

    // Request flags, wait counters, urgency flags and button edge history.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_prev_r <= {N_CH{1'b0}};
            wr_r        <= {N_CH{1'b0}};
            urgent_r    <= {N_CH{1'b0}};
            for (int i = 0; i < N_CH; i++) begin
                wait_r[i] <= {WAIT_W{1'b0}};
            end
        end else begin
            sync_prev_r <= wr_sync;
            wr_r        <= wr_next_s;
            urgent_r    <= urgent_next_s;
            for (int i = 0; i < N_CH; i++) begin
                wait_r[i] <= wait_next_s[i];
            end
        end
    end

    // Grant FSM with registered handshake outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            svc_valid_r <= 1'b0;
            svc_ch_r    <= {CH_W{1'b0}};
            busy_r      <= 1'b0;
            rr_ptr_r    <= {CH_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_s) begin
                        svc_ch_r    <= grant_s;
                        svc_valid_r <= 1'b1;
                        state_r     <= ST_OFFER;
                    end
                end
                ST_OFFER: begin
                    // svc_ch is frozen here; a transfer beats a simultaneous cancel.
                    if (svc_ready) begin
                        svc_valid_r <= 1'b0;
                        busy_r      <= 1'b1;
                        rr_ptr_r    <= rr_next_s;
                        state_r     <= ST_SERVE;
                    end else if (wr_clear[svc_ch_r]) begin
                        svc_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_SERVE: begin
                    if (svc_done) begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    svc_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign wr        = wr_r;
    assign urgent    = urgent_r;
    assign svc_valid = svc_valid_r;
    assign svc_ch    = svc_ch_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_walk_request_arbiter.sv
// Bench for walk_request_arbiter (N_CH=4, MAX_WAIT=8). Directed scenarios
// are followed by a random phase. The DUT is compared every cycle against a
// behavioural model that tracks pending flags, ages and grant status as
// plain arrays and integers.
module tb_walk_request_arbiter;

    localparam int N_CH     = 4;
    localparam int MAX_WAIT = 8;
    localparam int WAIT_W   = 4;
    localparam int CH_W     = 2;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [N_CH-1:0] wr_sync = '0;
    logic [N_CH-1:0] wr_clear = '0;
    logic            svc_ready = 1'b0;
    logic            svc_done = 1'b0;
    logic [N_CH-1:0] wr;
    logic [N_CH-1:0] urgent;
    logic            svc_valid;
    logic [CH_W-1:0] svc_ch;
    logic            busy;

    walk_request_arbiter #(
        .N_CH     (N_CH),
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_sync   (wr_sync),
        .wr_clear  (wr_clear),
        .svc_ready (svc_ready),
        .svc_done  (svc_done),
        .wr        (wr),
        .urgent    (urgent),
        .svc_valid (svc_valid),
        .svc_ch    (svc_ch),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit m_pend [N_CH];
    int m_age  [N_CH];
    bit m_prev [N_CH];
    bit m_valid;
    bit m_busy;
    int m_ch;
    int m_ptr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_urgent(input int i);
        return m_pend[i] && (m_age[i] == MAX_WAIT);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N_CH; i++) begin
            m_pend[i] = 0;
            m_age[i]  = 0;
            m_prev[i] = 0;
        end
        m_valid = 0;
        m_busy  = 0;
        m_ch    = 0;
        m_ptr   = 0;
    endtask

    task automatic model_clock();
        bit np [N_CH];
        int na [N_CH];
        bit any_urg;
        bit any_pend;
        bit accept;
        int pick;
        accept   = m_valid && svc_ready;
        any_urg  = 0;
        any_pend = 0;
        for (int i = 0; i < N_CH; i++) begin
            any_urg  = any_urg | m_urgent(i);
            any_pend = any_pend | m_pend[i];
        end
        pick = 0;
        for (int k = 0; k < N_CH; k++) begin
            int j;
            j = (m_ptr + k) % N_CH;
            if (any_urg ? m_urgent(j) : m_pend[j]) begin
                pick = j;
                break;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            bit rise;
            bit clr;
            rise  = wr_sync[i] && !m_prev[i];
            clr   = wr_clear[i] || (accept && i == m_ch);
            np[i] = (m_pend[i] || rise) && !clr;
            if (!np[i])         na[i] = 0;
            else if (m_pend[i]) na[i] = (m_age[i] < MAX_WAIT) ? m_age[i] + 1 : MAX_WAIT;
            else                na[i] = 0;
        end
        if (m_busy) begin
            if (svc_done) m_busy = 0;
        end else if (m_valid) begin
            if (svc_ready) begin
                m_valid = 0;
                m_busy  = 1;
                m_ptr   = (m_ch + 1) % N_CH;
            end else if (wr_clear[m_ch]) begin
                m_valid = 0;
            end
        end else if (any_pend) begin
            m_ch    = pick;
            m_valid = 1;
        end
        for (int i = 0; i < N_CH; i++) begin
            m_pend[i] = np[i];
            m_age[i]  = na[i];
            m_prev[i] = wr_sync[i];
        end
    endtask

    task automatic check_all(input string ph);
        logic [N_CH-1:0] ew;
        logic [N_CH-1:0] eu;
        for (int i = 0; i < N_CH; i++) begin
            ew[i] = m_pend[i];
            eu[i] = m_urgent(i);
        end
        chk({ph, ".wr"}, 32'(wr), 32'(ew));
        chk({ph, ".urgent"}, 32'(urgent), 32'(eu));
        chk({ph, ".svc_valid"}, 32'(svc_valid), 32'(m_valid));
        chk({ph, ".busy"}, 32'(busy), 32'(m_busy));
        if (m_valid || m_busy) chk({ph, ".svc_ch"}, 32'(svc_ch), 32'(m_ch));
    endtask

    task automatic tick(input string ph);
        @(posedge clk);
        model_clock();
        #1;
        check_all(ph);
    endtask

    initial begin
        int grants [3];
        int exp_order [3];
        int g;
        exp_order[0] = 0;
        exp_order[1] = 1;
        exp_order[2] = 3;

        // Reset state
        model_reset();
        #12;
        chk("rst.wr", 32'(wr), 32'd0);
        chk("rst.svc_valid", 32'(svc_valid), 32'd0);
        check_all("rst");
        reset_n = 1'b1;

        // Asynchronous reset while offering
        wr_sync = 4'b0011;
        tick("mid_rst.press");
        tick("mid_rst.offer");
        chk("mid_rst.offer_valid", 32'(svc_valid), 32'd1);
        #2;
        reset_n = 1'b0;
        wr_sync = 4'b0000;
        #1;
        model_reset();
        chk("mid_rst.wr", 32'(wr), 32'd0);
        chk("mid_rst.urgent", 32'(urgent), 32'd0);
        chk("mid_rst.svc_valid", 32'(svc_valid), 32'd0);
        chk("mid_rst.busy", 32'(busy), 32'd0);
        #1;
        reset_n = 1'b1;

        // Edge latch, latency, cancel in OFFER, held level does not re-latch
        svc_ready = 1'b0;
        wr_sync   = 4'b0100;
        tick("edge.t1");
        chk("edge.wr_after_1", 32'(wr), 32'h4);
        tick("edge.t2");
        chk("edge.valid_after_2", 32'(svc_valid), 32'd1);
        chk("edge.ch_after_2", 32'(svc_ch), 32'd2);
        for (int k = 0; k < 3; k++) tick("edge.hold");
        wr_clear = 4'b0100;
        tick("edge.cancel");
        chk("edge.cancel_wr", 32'(wr), 32'd0);
        chk("edge.cancel_valid", 32'(svc_valid), 32'd0);
        wr_clear = 4'b0000;
        tick("edge.held");
        chk("edge.held_no_reset", 32'(wr), 32'd0);
        wr_sync = 4'b0000;
        tick("edge.release");

        // Handshake and round-robin order
        wr_sync   = 4'b1011;
        svc_ready = 1'b1;
        tick("rr.press");
        wr_sync = 4'b0000;
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < 10 && !svc_valid; k++) tick("rr.wait");
            chk("rr.valid_seen", 32'(svc_valid), 32'd1);
            g = int'(svc_ch);
            grants[n] = g;
            tick("rr.xfer");
            chk("rr.busy_in_serve", 32'(busy), 32'd1);
            chk("rr.wr_cleared", 32'(wr[g]), 32'd0);
            tick("rr.serve1");
            tick("rr.serve2");
            svc_done = 1'b1;
            tick("rr.done");
            svc_done = 1'b0;
        end
        for (int n = 0; n < 3; n++) chk("rr.order", 32'(grants[n]), 32'(exp_order[n]));

        // Urgency: move rr_ptr to 2 by granting ch1, then age requests during SERVE
        wr_sync = 4'b0010;
        tick("urg.setup_press");
        wr_sync = 4'b0000;
        tick("urg.setup_offer");
        tick("urg.setup_xfer");
        svc_ready = 1'b0;
        wr_sync   = 4'b0010;
        for (int k = 1; k <= 12; k++) begin
            if (k == 3)  wr_sync = wr_sync | 4'b1000;
            if (k == 10) wr_sync = wr_sync | 4'b0100;
            tick("urg.age");
            if (k == 8)  chk("urg.not_yet", 32'(urgent), 32'd0);
            if (k == 9)  chk("urg.ch1_at_9", 32'(urgent), 32'h2);
            if (k == 11) chk("urg.ch3_at_11", 32'(urgent), 32'ha);
        end
        chk("urg.pending", 32'(wr), 32'he);
        svc_done = 1'b1;
        tick("urg.done");
        svc_done = 1'b0;
        tick("urg.offer");
        chk("urg.first_grant", 32'(svc_ch), 32'd3);
        chk("urg.first_valid", 32'(svc_valid), 32'd1);
        svc_ready = 1'b1;
        tick("urg.xfer");

        // Drain everything
        wr_sync  = 4'b0000;
        svc_done = 1'b1;
        for (int k = 0; k < 20; k++) tick("drain");
        svc_done  = 1'b0;
        svc_ready = 1'b0;
        tick("drain.end");
        chk("drain.empty", 32'(wr), 32'd0);

        // Clear collisions and ignored svc_done
        wr_sync  = 4'b0100;
        wr_clear = 4'b0100;
        tick("col.set_clr");
        chk("col.clear_wins", 32'(wr), 32'd0);
        wr_clear = 4'b0000;
        wr_sync  = 4'b0000;
        svc_done = 1'b1;
        tick("col.done_idle");
        chk("col.done_idle_busy", 32'(busy), 32'd0);
        svc_done = 1'b0;
        wr_sync  = 4'b0001;
        tick("col.press0");
        wr_sync = 4'b0000;
        tick("col.offer0");
        svc_done = 1'b1;
        tick("col.done_offer");
        chk("col.done_offer_valid", 32'(svc_valid), 32'd1);
        chk("col.done_offer_busy", 32'(busy), 32'd0);
        svc_done  = 1'b0;
        wr_clear  = 4'b0001;
        svc_ready = 1'b1;
        tick("col.clr_ready");
        chk("col.xfer_wins_busy", 32'(busy), 32'd1);
        chk("col.xfer_wins_valid", 32'(svc_valid), 32'd0);
        wr_clear  = 4'b0000;
        svc_ready = 1'b0;
        wr_sync   = 4'b0001;
        tick("col.relatch");
        chk("col.relatch_wr", 32'(wr), 32'h1);
        wr_sync  = 4'b0000;
        svc_done = 1'b1;
        tick("col.relatch_done");
        svc_done = 1'b0;
        tick("col.relatch_offer");
        chk("col.relatch_valid", 32'(svc_valid), 32'd1);
        chk("col.relatch_ch", 32'(svc_ch), 32'd0);
        svc_ready = 1'b1;
        tick("col.relatch_xfer");

        // Random phase
        for (int n = 0; n < 800; n++) begin
            for (int i = 0; i < N_CH; i++) begin
                if ($urandom_range(0, 5) == 0) wr_sync[i] = ~wr_sync[i];
                wr_clear[i] = ($urandom_range(0, 24) == 0);
            end
            svc_ready = ($urandom_range(0, 2) == 0);
            svc_done  = ($urandom_range(0, 3) == 0);
            if (n == 400) begin
                #2;
                reset_n = 1'b0;
                wr_sync = 4'b0000;
                #1;
                model_reset();
                check_all("rand.reset");
                #1;
                reset_n = 1'b1;
            end
            tick("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
